// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side inputs, hazard controls, forwarding sources and ALU-facing outputs
// exchanged between the ID/EX operand stage and its neighbours.
interface id_ex_operand_stage_if #(
    parameter int DATA_W = 32
);
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [1:0]        id_ALUOp;
    logic [5:0]        id_funct;
    logic [5:0]        id_ctrl;
    logic              exmem_we;
    logic [4:0]        exmem_rd;
    logic [DATA_W-1:0] exmem_data;
    logic              memwb_we;
    logic [4:0]        memwb_rd;
    logic [DATA_W-1:0] memwb_data;
    logic [DATA_W-1:0] entradaA;
    logic [DATA_W-1:0] entradaB;
    logic [3:0]        entradaControl;
    logic              ex_valid;
    logic [3:0]        ex_ctrl;
    logic [4:0]        ex_write_reg;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_illegal;

    // Upstream side: decode, hazard unit and later pipeline stages
    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_ALUOp, id_funct, id_ctrl,
               exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
        input  entradaA, entradaB, entradaControl, ex_valid, ex_ctrl,
               ex_write_reg, ex_store_data, ex_illegal
    );

    // The operand stage itself
    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_ALUOp, id_funct, id_ctrl,
               exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
        output entradaA, entradaB, entradaControl, ex_valid, ex_ctrl,
               ex_write_reg, ex_store_data, ex_illegal
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: latches decoded fields, decodes the ALU
// control code and forwards EX/MEM and MEM/WB results into the operands.
module id_ex_operand_stage #(
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    id_ex_operand_stage_if.slave bus
);

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } aluCtrl_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rsData;
        logic [DATA_W-1:0] rtData;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [1:0]        aluOp;
        logic [5:0]        funct;
        logic [5:0]        ctrl;
    } idExReg_t;

    idExReg_t exReg;
    idExReg_t idFields;
    aluCtrl_e aluCtrl;
    logic     functIllegal;
    logic [DATA_W-1:0] rsForwarded;
    logic [DATA_W-1:0] rtForwarded;

    // A non-valid ID slot is captured as an all-zero bubble so nothing downstream acts on it
    always_comb begin
        idFields = '0;
        if (bus.id_valid) begin
            idFields.valid  = 1'b1;
            idFields.rsData = bus.id_rs_data;
            idFields.rtData = bus.id_rt_data;
            idFields.imm    = bus.id_imm;
            idFields.rs     = bus.id_rs;
            idFields.rt     = bus.id_rt;
            idFields.rd     = bus.id_rd;
            idFields.aluOp  = bus.id_ALUOp;
            idFields.funct  = bus.id_funct;
            idFields.ctrl   = bus.id_ctrl;
        end
    end

    // Flush beats stall; stall holds the whole register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exReg <= '0;
        end else if (bus.flush) begin
            exReg <= '0;
        end else if (!bus.stall) begin
            exReg <= idFields;
        end
    end

    function automatic logic [DATA_W-1:0] forwardOperand(
        input logic [4:0]        idx,
        input logic [DATA_W-1:0] regVal,
        input logic              exWe,
        input logic [4:0]        exRd,
        input logic [DATA_W-1:0] exData,
        input logic              wbWe,
        input logic [4:0]        wbRd,
        input logic [DATA_W-1:0] wbData
    );
        logic [DATA_W-1:0] result;
        result = regVal;
        // The younger EX/MEM result wins; $zero is hardwired and never forwarded
        if (exWe && (exRd != 5'd0) && (exRd == idx)) begin
            result = exData;
        end else if (wbWe && (wbRd != 5'd0) && (wbRd == idx)) begin
            result = wbData;
        end
        return result;
    endfunction

    always_comb begin
        rsForwarded = forwardOperand(exReg.rs, exReg.rsData,
                                     bus.exmem_we, bus.exmem_rd, bus.exmem_data,
                                     bus.memwb_we, bus.memwb_rd, bus.memwb_data);
        rtForwarded = forwardOperand(exReg.rt, exReg.rtData,
                                     bus.exmem_we, bus.exmem_rd, bus.exmem_data,
                                     bus.memwb_we, bus.memwb_rd, bus.memwb_data);
    end

    // ALU control decode; unknown R-type functs fall back to add and raise the flag
    always_comb begin
        aluCtrl      = ALU_ADD;
        functIllegal = 1'b0;
        case (exReg.aluOp)
            2'b00: aluCtrl = ALU_ADD;
            2'b01: aluCtrl = ALU_SUB;
            2'b11: aluCtrl = ALU_OR;
            default: begin
                case (exReg.funct)
                    6'b100000: aluCtrl = ALU_ADD;
                    6'b100010: aluCtrl = ALU_SUB;
                    6'b100100: aluCtrl = ALU_AND;
                    6'b100101: aluCtrl = ALU_OR;
                    6'b100111: aluCtrl = ALU_NOR;
                    6'b101010: aluCtrl = ALU_SLT;
                    default: begin
                        aluCtrl      = ALU_ADD;
                        functIllegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // ctrl layout: {ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg}
    assign bus.entradaA       = rsForwarded;
    assign bus.entradaB       = exReg.ctrl[5] ? exReg.imm : rtForwarded;
    assign bus.entradaControl = aluCtrl;
    assign bus.ex_valid       = exReg.valid;
    assign bus.ex_ctrl        = exReg.valid ? exReg.ctrl[3:0] : 4'd0;
    assign bus.ex_write_reg   = exReg.ctrl[4] ? exReg.rd : exReg.rt;
    assign bus.ex_store_data  = rtForwarded;
    assign bus.ex_illegal     = exReg.valid & functIllegal;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register directly upstream of the ALU. Latches decoded-instruction fields from ID, decodes ALUOp/funct into the ALU's 4-bit entradaControl, and resolves RAW hazards by forwarding EX/MEM and MEM/WB results into entradaA/entradaB. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
DATA_W, 32, datapath width of operands, immediates and forwarded results.

Ports:
clk  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold the ID/EX register contents
flush  in  1  load a bubble; overrides stall
id_valid  in  1  ID stage holds a real instruction
id_rs_data  in  DATA_W  register-file read data for rs
id_rt_data  in  DATA_W  register-file read data for rt
id_imm  in  DATA_W  sign-extended immediate
id_rs  in  5  rs index
id_rt  in  5  rt index
id_rd  in  5  rd index
id_ALUOp  in  2  main-decoder ALU class
id_funct  in  6  instruction funct field
id_ctrl  in  6  {ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg}
exmem_we  in  1  EX/MEM stage will write a register
exmem_rd  in  5  EX/MEM destination index
exmem_data  in  DATA_W  EX/MEM ALU result
memwb_we  in  1  MEM/WB stage will write a register
memwb_rd  in  5  MEM/WB destination index
memwb_data  in  DATA_W  MEM/WB writeback value
entradaA  out  DATA_W  ALU operand A
entradaB  out  DATA_W  ALU operand B
entradaControl  out  4  ALU operation code
ex_valid  out  1  EX stage holds a real instruction
ex_ctrl  out  4  {RegWrite, MemRead, MemWrite, MemtoReg}, gated by ex_valid
ex_write_reg  out  5  RegDst ? rd : rt
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_illegal  out  1  R-type funct not supported

Behaviour:
- Reset (async, reset_n=0): all registered fields cleared. Outputs: entradaA=0, entradaB=0, entradaControl=2, ex_valid=0, ex_ctrl=0, ex_write_reg=0, ex_store_data=0, ex_illegal=0.
- Each rising edge: flush=1 -> bubble (all fields 0, same as reset); else stall=1 -> hold; else capture all id_* inputs. id_valid=0 is captured as a bubble.
- Latency: one cycle from ID inputs to EX outputs. Forwarding and decode are combinational from registered fields and current exmem_*/memwb_* inputs (same-cycle).
- Forwarding for operand X in {rs, rt}: if exmem_we && exmem_rd!=0 && exmem_rd==X -> exmem_data; elsif memwb_we && memwb_rd!=0 && memwb_rd==X -> memwb_data; else registered read data. EX/MEM has priority. Register 0 is never forwarded.
- entradaA = fwd(rs). ex_store_data = fwd(rt). entradaB = ALUSrc ? imm : fwd(rt).
- entradaControl: ALUOp 00 -> 2 (add); 01 -> 6 (sub); 11 -> 1 (or, ori); 10 -> by funct: 100000->2, 100010->6, 100100->0, 100101->1, 100111->12, 101010->7; any other funct -> 2, with ex_illegal=1 only when ex_valid=1.
- ex_ctrl and ex_illegal forced to 0 when ex_valid=0.
- flush and stall asserted together: flush wins.
- Reset mid-stall: bubble immediately; stall is ignored while reset_n=0.

Test Plan:
- Reset, then id_rs_data=3, id_rt_data=2, ALUOp=10, funct=100000, id_valid=1, one clock -> entradaA=3, entradaB=2, entradaControl=2, ex_valid=1.
- Sweep funct 100100/100101/100010/100111/101010 -> entradaControl 0/1/6/12/7. funct=000000 -> entradaControl=2, ex_illegal=1.
- id_rs=5, exmem_we=1, exmem_rd=5, exmem_data=0xAA, memwb_we=1, memwb_rd=5, memwb_data=0xBB -> entradaA=0xAA. Drop exmem_we -> 0xBB. Set rd=0 on both -> rs data.
- ALUSrc=1, id_imm=0xFFFFFFFC, rt forwarded to 0x11 -> entradaB=0xFFFFFFFC, ex_store_data=0x11.
- Load instruction A, then stall=1 with new ID inputs for 3 cycles -> outputs stay A. flush=1 with stall=1 -> ex_valid=0, ex_ctrl=0, entradaControl=2.
- Assert reset_n=0 asynchronously between clock edges while valid -> outputs clear immediately, before the next edge.
